ad_cache_reader: RTL

- Read-side sequencer for the ping-pong ADC cache, in the cache read-clock domain.
- On each cache half-swap pulse it reads exactly one frame (FRAME_LEN words) from the just-completed half.
- Compensates for the RAM read latency and delivers the words as a valid/ready stream with an end-of-frame marker.
- Detects frames the consumer failed to drain before the next swap.

---
 rtl/ad_cache_reader.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ad_cache_reader.sv
// rtl/ad_cache_reader.sv - ping-pong ADC cache read sequencer with credit-gated skid FIFO output
module ad_cache_reader #(
   parameter int DATA_NBIT  = 16,
   parameter int FRAME_LEN  = 1024,
   parameter int RD_LAT     = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic                 switch,
   output logic                 rd,
   input  logic [DATA_NBIT-1:0] rdata,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [DATA_NBIT-1:0] m_data,
   output logic                 m_last,
   output logic [15:0]          frame_cnt,
   output logic                 overrun,
   input  logic                 clr_ovr
);
   localparam int IW = $clog2(FRAME_LEN) + 1;
   localparam int FW = $clog2(RD_LAT + 1) + 1;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = CW + 1;
   localparam logic [IW-1:0] L_FRAME = IW'(FRAME_LEN);
   localparam logic [IW-1:0] L_LAST  = IW'(FRAME_LEN - 1);
   localparam logic [SW-1:0] L_DEPTH = SW'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

   state_t               r_state;
   logic [IW-1:0]        r_issued;
   logic [IW-1:0]        r_ret_idx;
   logic [RD_LAT-1:0]    r_rd_pipe;
   logic [DATA_NBIT-1:0] r_mem_data [FIFO_DEPTH];
   logic                 r_mem_last [FIFO_DEPTH];
   logic [PW-1:0]        r_wptr;
   logic [PW-1:0]        r_rptr;
   logic [CW-1:0]        r_count;
   logic [15:0]          r_frame_cnt;
   logic                 r_overrun;

   logic [FW-1:0]        w_in_flight;
   logic [SW-1:0]        w_credit_used;
   logic                 w_start;
   logic                 w_abort;
   logic                 w_rd;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_last_acc;

   // Each pipe bit is one outstanding rd; the oldest bit marks the word on rdata this cycle.
   always_comb begin
      w_in_flight = '0;
      for (int i = 0; i < RD_LAT; i++) begin
         w_in_flight = w_in_flight + FW'(r_rd_pipe[i]);
      end
   end

   assign w_credit_used = SW'(w_in_flight) + SW'(r_count);
   assign w_start       = switch && enable && (r_state == S_IDLE);
   assign w_abort       = switch && (r_state != S_IDLE);
   assign w_rd          = (r_state == S_READ) && !switch && (r_issued < L_FRAME) &&
                          (w_credit_used < L_DEPTH);
   assign w_push        = r_rd_pipe[RD_LAT-1] && !w_abort;
   assign w_pop         = (r_count != '0) && m_ready;
   assign w_last_acc    = w_pop && r_mem_last[r_rptr];

   assign rd        = w_rd;
   assign m_valid   = (r_count != '0);
   assign m_data    = r_mem_data[r_rptr];
   assign m_last    = m_valid && r_mem_last[r_rptr];
   assign frame_cnt = r_frame_cnt;
   assign overrun   = r_overrun;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_issued    <= '0;
         r_ret_idx   <= '0;
         r_rd_pipe   <= '0;
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_count     <= '0;
         r_frame_cnt <= '0;
         r_overrun   <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem_data[i] <= '0;
            r_mem_last[i] <= 1'b0;
         end
      end else begin
         r_rd_pipe <= (r_rd_pipe << 1) | RD_LAT'(w_rd);
         if (w_push) begin
            r_mem_data[r_wptr] <= rdata;
            r_mem_last[r_wptr] <= (r_ret_idx == L_LAST);
            r_wptr             <= r_wptr + 1'b1;
            r_ret_idx          <= r_ret_idx + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
         if (w_last_acc) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
         end
         if (clr_ovr) begin
            r_overrun <= 1'b0;
         end
         if (w_rd) begin
            r_issued <= r_issued + 1'b1;
         end

         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_state   <= S_READ;
                  r_issued  <= '0;
                  r_ret_idx <= '0;
               end
            end
            S_READ: begin
               if (w_rd && (r_issued == L_LAST)) begin
                  r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (w_last_acc && (w_in_flight == '0)) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase

         // A swap mid-frame restarts on the new half; dropping the pipe bits discards stale returns.
         if (w_abort) begin
            r_overrun <= 1'b1;
            r_state   <= S_READ;
            r_issued  <= '0;
            r_ret_idx <= '0;
            r_rd_pipe <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
         end
      end
   end
endmodule
